// File: rtl/core_fetch_queue.sv
// Instruction fetch front end: issues groups of up to FETCH_W reads with per-port
// handshakes and buffers the returned instructions in a DEPTH-entry queue.
module core_fetch_queue #(
  parameter int unsigned     FETCH_W  = 2,
  parameter int unsigned     DEPTH    = 8,
  parameter int unsigned     PC_W     = 8,
  parameter int unsigned     INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = 8'h10
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [1:0]                          exec_i,
  input  logic                                pc_wen_i,
  input  logic [PC_W-1:0]                     pc_i,
  input  logic                                redirect_i,
  input  logic [PC_W-1:0]                     redirect_pc_i,
  input  logic                                halt_i,
  output logic [FETCH_W-1:0]                  mem_val_o,
  output logic [FETCH_W-1:0][PC_W-1:0]        mem_addr_o,
  input  logic [FETCH_W-1:0]                  mem_rdy_i,
  input  logic [FETCH_W-1:0][INSTR_W-1:0]     mem_rdata_i,
  output logic [FETCH_W-1:0]                  out_val_o,
  output logic [FETCH_W-1:0][INSTR_W-1:0]     out_instr_o,
  output logic [FETCH_W-1:0][PC_W-1:0]        out_pc_o,
  input  logic [$clog2(FETCH_W+1)-1:0]        deq_cnt_i,
  output logic [$clog2(DEPTH+1)-1:0]          count_o,
  output logic [PC_W-1:0]                     pc_o,
  output logic                                halted_o,
  output logic                                idle_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned DEQ_W = $clog2(FETCH_W + 1);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  state_e                          state_r, state_nx_s;
  logic [PC_W-1:0]                 pc_r, pc_nx_s;
  logic [CNT_W-1:0]                count_r, count_nx_s;
  logic [PTR_W-1:0]                rd_ptr_r, rd_ptr_nx_s;
  logic [PTR_W-1:0]                wr_ptr_r, wr_ptr_nx_s;
  logic                            pend_r, pend_nx_s;
  logic [DEQ_W-1:0]                grp_size_r, grp_size_nx_s;
  logic [FETCH_W-1:0]              lat_vld_r, lat_vld_nx_s;
  logic [FETCH_W-1:0][INSTR_W-1:0] lat_data_r, lat_data_nx_s;

  logic [INSTR_W-1:0]              q_instr_r [DEPTH];
  logic [PC_W-1:0]                 q_pc_r    [DEPTH];

  logic                            flush_s;
  logic                            run_mode_s;
  logic                            step_mode_s;
  logic                            start_s;
  logic                            active_s;
  logic                            done_s;
  logic [DEQ_W-1:0]                cur_size_s;
  logic [FETCH_W-1:0]              hs_s;
  logic [CNT_W-1:0]                deq_s;
  logic [CNT_W-1:0]                enq_s;

  assign flush_s     = pc_wen_i | halt_i | redirect_i;
  assign run_mode_s  = (exec_i == 2'd1);
  assign step_mode_s = (exec_i == 2'd2);

  // Group issue decision, per-port request/handshake and group completion
  always_comb begin
    start_s    = 1'b0;
    cur_size_s = grp_size_r;
    done_s     = 1'b0;
    mem_val_o  = '0;
    mem_addr_o = '0;
    hs_s       = '0;
    if (state_r == ST_RUN && !pend_r) begin
      if (run_mode_s) begin
        start_s    = ((CNT_W'(DEPTH) - count_r) >= CNT_W'(FETCH_W));
        cur_size_s = DEQ_W'(FETCH_W);
      end else if (step_mode_s) begin
        start_s    = (count_r == '0);
        cur_size_s = DEQ_W'(1);
      end else begin
        start_s    = 1'b0;
      end
    end else begin
      start_s = 1'b0;
    end
    // Any flush or reset cancels the group before a handshake can be lost
    active_s = (pend_r | start_s) & ~rst_i & ~flush_s;
    done_s   = active_s;
    for (int k = 0; k < FETCH_W; k++) begin
      mem_addr_o[k] = pc_r + PC_W'(k);
      mem_val_o[k]  = active_s & (DEQ_W'(k) < cur_size_s) & ~lat_vld_r[k];
      hs_s[k]       = mem_val_o[k] & mem_rdy_i[k];
      done_s        = done_s & (~(DEQ_W'(k) < cur_size_s) | lat_vld_r[k] | hs_s[k]);
    end
  end

  assign deq_s = (CNT_W'(deq_cnt_i) > count_r) ? count_r : CNT_W'(deq_cnt_i);
  assign enq_s = done_s ? CNT_W'(cur_size_s) : '0;

  // Next-state: flush sources in priority order, otherwise queue and group update
  always_comb begin
    state_nx_s    = state_r;
    pc_nx_s       = pc_r;
    count_nx_s    = count_r;
    rd_ptr_nx_s   = rd_ptr_r;
    wr_ptr_nx_s   = wr_ptr_r;
    pend_nx_s     = pend_r;
    grp_size_nx_s = grp_size_r;
    lat_vld_nx_s  = lat_vld_r;
    lat_data_nx_s = lat_data_r;
    if (flush_s) begin
      count_nx_s   = '0;
      rd_ptr_nx_s  = wr_ptr_r;
      pend_nx_s    = 1'b0;
      lat_vld_nx_s = '0;
      if (pc_wen_i) begin
        state_nx_s = ST_RUN;
        pc_nx_s    = pc_i;
      end else if (halt_i) begin
        state_nx_s = ST_HALTED;
      end else begin
        pc_nx_s = redirect_pc_i;
      end
    end else begin
      count_nx_s  = count_r + enq_s - deq_s;
      rd_ptr_nx_s = rd_ptr_r + PTR_W'(deq_s);
      if (done_s) begin
        wr_ptr_nx_s  = wr_ptr_r + PTR_W'(cur_size_s);
        pc_nx_s      = pc_r + PC_W'(cur_size_s);
        pend_nx_s    = 1'b0;
        lat_vld_nx_s = '0;
      end else if (active_s) begin
        pend_nx_s     = 1'b1;
        grp_size_nx_s = cur_size_s;
        for (int k = 0; k < FETCH_W; k++) begin
          if (hs_s[k]) begin
            lat_vld_nx_s[k]  = 1'b1;
            lat_data_nx_s[k] = mem_rdata_i[k];
          end else begin
            lat_vld_nx_s[k]  = lat_vld_r[k];
            lat_data_nx_s[k] = lat_data_r[k];
          end
        end
      end else begin
        pend_nx_s = pend_r;
      end
      case (state_r)
        ST_HALTED: state_nx_s = (run_mode_s || step_mode_s) ? ST_HALTED : ST_RUN;
        ST_RUN:    state_nx_s = ST_RUN;
        default:   state_nx_s = ST_RUN;
      endcase
    end
  end

  // Control state register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= ST_RUN;
      pc_r       <= RESET_PC;
      count_r    <= '0;
      rd_ptr_r   <= '0;
      wr_ptr_r   <= '0;
      pend_r     <= 1'b0;
      grp_size_r <= '0;
      lat_vld_r  <= '0;
      lat_data_r <= '0;
    end else begin
      state_r    <= state_nx_s;
      pc_r       <= pc_nx_s;
      count_r    <= count_nx_s;
      rd_ptr_r   <= rd_ptr_nx_s;
      wr_ptr_r   <= wr_ptr_nx_s;
      pend_r     <= pend_nx_s;
      grp_size_r <= grp_size_nx_s;
      lat_vld_r  <= lat_vld_nx_s;
      lat_data_r <= lat_data_nx_s;
    end
  end

  // Queue storage: a completed group is written in port order
  always_ff @(posedge clk_i) begin
    if (done_s) begin
      for (int k = 0; k < FETCH_W; k++) begin
        if (DEQ_W'(k) < cur_size_s) begin
          q_instr_r[wr_ptr_r + PTR_W'(k)] <= lat_vld_r[k] ? lat_data_r[k] : mem_rdata_i[k];
          q_pc_r[wr_ptr_r + PTR_W'(k)]    <= pc_r + PC_W'(k);
        end
      end
    end
  end

  // Window onto the oldest FETCH_W entries
  always_comb begin
    out_val_o   = '0;
    out_instr_o = '0;
    out_pc_o    = '0;
    for (int k = 0; k < FETCH_W; k++) begin
      out_val_o[k]   = (CNT_W'(k) < count_r);
      out_instr_o[k] = q_instr_r[rd_ptr_r + PTR_W'(k)];
      out_pc_o[k]    = q_pc_r[rd_ptr_r + PTR_W'(k)];
    end
  end

  assign count_o  = count_r;
  assign pc_o     = pc_r;
  assign halted_o = (state_r == ST_HALTED);
  assign idle_o   = ((count_r == '0) && !pend_r) || (state_r == ST_HALTED);

endmodule

// File: tb/tb_core_fetch_queue.sv
// Directed bench for core_fetch_queue (FETCH_W=2, DEPTH=8, PC_W=8, INSTR_W=16).
module tb_core_fetch_queue;

  localparam int FW = 2;

  logic               clk;
  logic               rst;
  logic [1:0]         exec;
  logic               pc_wen;
  logic [7:0]         pc_in;
  logic               redirect;
  logic [7:0]         redirect_pc;
  logic               halt;
  logic [FW-1:0]      mem_val;
  logic [FW-1:0][7:0] mem_addr;
  logic [FW-1:0]      rdy;
  logic [FW-1:0][15:0] rdata;
  logic [FW-1:0]      out_val;
  logic [FW-1:0][15:0] out_instr;
  logic [FW-1:0][7:0] out_pc;
  logic [1:0]         deq;
  logic [3:0]         count;
  logic [7:0]         pc_o;
  logic               halted;
  logic               idle;

  int checks = 0;
  int errors = 0;

  core_fetch_queue #(
    .FETCH_W(2), .DEPTH(8), .PC_W(8), .INSTR_W(16), .RESET_PC(8'h10)
  ) dut (
    .clk_i(clk), .rst_i(rst), .exec_i(exec), .pc_wen_i(pc_wen), .pc_i(pc_in),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc), .halt_i(halt),
    .mem_val_o(mem_val), .mem_addr_o(mem_addr), .mem_rdy_i(rdy), .mem_rdata_i(rdata),
    .out_val_o(out_val), .out_instr_o(out_instr), .out_pc_o(out_pc),
    .deq_cnt_i(deq), .count_o(count), .pc_o(pc_o), .halted_o(halted), .idle_o(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] instr_of(input logic [7:0] a);
    return {~a, a};
  endfunction

  // Memory model: data only meaningful while the port requests
  always_comb begin
    for (int k = 0; k < FW; k++) begin
      if (mem_val[k]) rdata[k] = instr_of(mem_addr[k]);
      else            rdata[k] = 16'hDEAD;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; exec = 2'd1; pc_wen = 1'b0; pc_in = 8'h00; redirect = 1'b0;
    redirect_pc = 8'h00; halt = 1'b0; rdy = 2'b11; deq = 2'd0;

    // Reset: no requests while rst is high
    #1; chk("rst_val_a", 32'(mem_val), 32'd0);
    tick(); chk("rst_val_b", 32'(mem_val), 32'd0);
    tick();
    rst = 1'b0; exec = 2'd0; #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_pc", 32'(pc_o), 32'h10);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_outval", 32'(out_val), 32'd0);

    // Full throughput until full
    exec = 2'd1;
    for (int g = 0; g < 4; g++) begin
      #1;
      chk("run_val", 32'(mem_val), 32'd3);
      chk("run_a0", 32'(mem_addr[0]), 32'(8'h10 + 2 * g));
      chk("run_a1", 32'(mem_addr[1]), 32'(8'h11 + 2 * g));
      tick();
      chk("run_count", 32'(count), 32'(2 * (g + 1)));
    end
    #1;
    chk("full_val", 32'(mem_val), 32'd0);
    chk("full_pc", 32'(pc_o), 32'h18);
    chk("full_outval", 32'(out_val), 32'd3);
    chk("full_outpc0", 32'(out_pc[0]), 32'h10);
    chk("full_outpc1", 32'(out_pc[1]), 32'h11);
    chk("full_instr1", 32'(out_instr[1]), 32'(instr_of(8'h11)));
    tick();

    // Dequeue with simultaneous enqueue across pointer wrap
    exec = 2'd0; deq = 2'd2; tick();
    chk("deq_count", 32'(count), 32'd6);
    chk("deq_outpc0", 32'(out_pc[0]), 32'h12);
    exec = 2'd1; #1;
    chk("bal_val", 32'(mem_val), 32'd3);
    chk("bal_a0", 32'(mem_addr[0]), 32'h18);
    tick();
    chk("bal_count1", 32'(count), 32'd6);
    chk("bal_outpc0_1", 32'(out_pc[0]), 32'h14);
    tick();
    chk("bal_count2", 32'(count), 32'd6);
    chk("bal_outpc1_2", 32'(out_pc[1]), 32'h17);
    tick();
    exec = 2'd0; deq = 2'd0; #1;
    chk("bal_count3", 32'(count), 32'd6);
    chk("wrap_outpc0", 32'(out_pc[0]), 32'h18);
    chk("wrap_outpc1", 32'(out_pc[1]), 32'h19);
    chk("wrap_instr1", 32'(out_instr[1]), 32'(instr_of(8'h19)));

    // Manual PC load flushes; port 1 ready arrives late
    pc_wen = 1'b1; pc_in = 8'h10; #1;
    chk("wen_val", 32'(mem_val), 32'd0);
    tick();
    pc_wen = 1'b0; #1;
    chk("wen_count", 32'(count), 32'd0);
    chk("wen_pc", 32'(pc_o), 32'h10);
    exec = 2'd1; rdy = 2'b01; #1;
    chk("late_val0", 32'(mem_val), 32'd3);
    tick();
    chk("late_val1", 32'(mem_val), 32'd2);
    chk("late_count1", 32'(count), 32'd0);
    chk("late_pc1", 32'(pc_o), 32'h10);
    chk("late_idle1", 32'(idle), 32'd0);
    tick();
    chk("late_val2", 32'(mem_val), 32'd2);
    tick();
    rdy = 2'b11; #1;
    chk("late_val3", 32'(mem_val), 32'd2);
    tick();
    exec = 2'd0; #1;
    chk("late_count", 32'(count), 32'd2);
    chk("late_pc", 32'(pc_o), 32'h12);
    chk("late_outpc0", 32'(out_pc[0]), 32'h10);
    chk("late_instr0", 32'(out_instr[0]), 32'(instr_of(8'h10)));
    chk("late_instr1", 32'(out_instr[1]), 32'(instr_of(8'h11)));

    // Redirect with a pending group and four queued entries
    exec = 2'd1; tick();
    rdy = 2'b00; #1;
    chk("pre_redir_count", 32'(count), 32'd4);
    chk("pre_redir_a0", 32'(mem_addr[0]), 32'h14);
    tick();
    redirect = 1'b1; redirect_pc = 8'h40; rdy = 2'b11; #1;
    chk("redir_val", 32'(mem_val), 32'd0);
    tick();
    redirect = 1'b0; exec = 2'd0; #1;
    chk("redir_count", 32'(count), 32'd0);
    chk("redir_pc", 32'(pc_o), 32'h40);
    chk("redir_idle", 32'(idle), 32'd1);
    chk("redir_outval", 32'(out_val), 32'd0);
    exec = 2'd1; #1;
    chk("redir_a0", 32'(mem_addr[0]), 32'h40);
    tick();
    exec = 2'd0; #1;
    chk("redir_count2", 32'(count), 32'd2);
    chk("redir_outpc0", 32'(out_pc[0]), 32'h40);
    chk("redir_instr1", 32'(out_instr[1]), 32'(instr_of(8'h41)));

    // Single step across PC wrap
    pc_wen = 1'b1; pc_in = 8'hFF; tick();
    pc_wen = 1'b0; exec = 2'd2; #1;
    chk("step_val0", 32'(mem_val), 32'd1);
    chk("step_a0", 32'(mem_addr[0]), 32'hFF);
    tick();
    chk("step_count1", 32'(count), 32'd1);
    chk("step_pc1", 32'(pc_o), 32'h00);
    chk("step_val1", 32'(mem_val), 32'd0);
    chk("step_outpc0", 32'(out_pc[0]), 32'hFF);
    tick();
    chk("step_val2", 32'(mem_val), 32'd0);
    deq = 2'd1; #1;
    chk("step_val3", 32'(mem_val), 32'd0);
    tick();
    deq = 2'd0; #1;
    chk("step_count2", 32'(count), 32'd0);
    chk("step_val4", 32'(mem_val), 32'd1);
    chk("step_a0b", 32'(mem_addr[0]), 32'h00);
    tick();
    chk("step_count3", 32'(count), 32'd1);
    chk("step_outpc0b", 32'(out_pc[0]), 32'h00);
    chk("step_outval", 32'(out_val), 32'd1);

    // Halt, held exec, release via exec=0
    exec = 2'd1; halt = 1'b1; #1;
    chk("halt_val", 32'(mem_val), 32'd0);
    tick();
    halt = 1'b0; #1;
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_count", 32'(count), 32'd0);
    chk("halt_pc", 32'(pc_o), 32'h01);
    chk("halt_val1", 32'(mem_val), 32'd0);
    chk("halt_idle", 32'(idle), 32'd1);
    tick();
    chk("halt_held", 32'(halted), 32'd1);
    chk("halt_val2", 32'(mem_val), 32'd0);
    exec = 2'd0; tick();
    exec = 2'd1; #1;
    chk("resume_halted", 32'(halted), 32'd0);
    chk("resume_val", 32'(mem_val), 32'd3);
    chk("resume_a0", 32'(mem_addr[0]), 32'h01);
    chk("resume_a1", 32'(mem_addr[1]), 32'h02);
    tick();
    exec = 2'd3; #1;
    chk("mode3_count", 32'(count), 32'd2);
    chk("mode3_pc", 32'(pc_o), 32'h03);
    chk("mode3_val", 32'(mem_val), 32'd0);

    // Reset in the middle of a group
    exec = 2'd1; rdy = 2'b00; #1;
    chk("mid_a0", 32'(mem_addr[0]), 32'h03);
    tick();
    rst = 1'b1; #1;
    chk("mid_rst_val", 32'(mem_val), 32'd0);
    tick();
    rst = 1'b0; exec = 2'd0; rdy = 2'b11; #1;
    chk("mid_pc", 32'(pc_o), 32'h10);
    chk("mid_count", 32'(count), 32'd0);
    chk("mid_idle", 32'(idle), 32'd1);
    chk("mid_outval", 32'(out_val), 32'd0);
    exec = 2'd1; #1;
    chk("mid_val", 32'(mem_val), 32'd3);
    chk("mid_a0b", 32'(mem_addr[0]), 32'h10);
    tick();
    exec = 2'd0; #1;
    chk("mid_count2", 32'(count), 32'd2);
    chk("mid_instr0", 32'(out_instr[0]), 32'(instr_of(8'h10)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/core_fetch_queue.md
CORE_FETCH_QUEUE -- requirements
Module: core_fetch_queue

Interface
REQ-001 SHALL have parameter FETCH_W, default 2, meaning fetch ports per group (1..4).
REQ-002 SHALL have parameter DEPTH, default 8, meaning queue entries (power of 2, >= 2*FETCH_W).
REQ-003 SHALL have parameters PC_W (default 8, PC width), INSTR_W (default 16, instruction width) and RESET_PC (default 8'h10, PC after reset).
REQ-004 SHALL have port clk_i  in  1  meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_i  in  1  meaning reset; synchronous and active-high.
REQ-006 SHALL have port exec_i  in  2  meaning fetch mode: 0 stop, 1 run, 2 single step, 3 treated as 0.
REQ-007 SHALL have ports pc_wen_i in 1 and pc_i in PC_W, meaning manual PC load.
REQ-008 SHALL have ports redirect_i in 1 and redirect_pc_i in PC_W, meaning jump redirect.
REQ-009 SHALL have port halt_i  in  1  meaning halt: flush and stop.
REQ-010 SHALL have ports mem_val_o out [FETCH_W], mem_addr_o out [FETCH_W][PC_W], mem_rdy_i in [FETCH_W] and mem_rdata_i in [FETCH_W][INSTR_W], meaning per-port read handshake; rdata is valid in the cycle val&&rdy.
REQ-011 SHALL have ports out_val_o out [FETCH_W], out_instr_o out [FETCH_W][INSTR_W] and out_pc_o out [FETCH_W][PC_W], meaning the oldest FETCH_W entries.
REQ-012 SHALL have port deq_cnt_i  in  clog2(FETCH_W+1)  meaning entries consumed this cycle.
REQ-013 SHALL have ports count_o out clog2(DEPTH+1) (occupancy), pc_o out PC_W (next fetch PC), halted_o out 1 and idle_o out 1.

Function
REQ-014 SHALL hold state HALTED or RUN; RUN with exec_i=0 issues nothing.
REQ-015 SHALL apply priority rst_i > pc_wen_i > halt_i > redirect_i > dequeue/enqueue.
REQ-016 In RUN, exec_i=1: SHALL issue a group at pc_o..pc_o+FETCH_W-1 when DEPTH-count_o >= FETCH_W, using the registered count and not crediting a same-cycle dequeue.
REQ-017 In RUN, exec_i=2: SHALL issue only port 0 (group size 1) when count_o=0 and no group is pending; other ports keep mem_val_o=0.
REQ-018 For each issued port k, mem_addr_o[k] SHALL equal pc_o+k mod 2^PC_W, and mem_val_o[k] SHALL be 1 until that port handshakes.
REQ-019 A port handshaking before its group completes SHALL latch mem_rdata_i and drop mem_val_o from the next cycle.
REQ-020 The group SHALL complete in the cycle all its ports are latched or handshaking; at that edge it SHALL enqueue in port order and pc_o SHALL advance by the group size (mod 2^PC_W).
REQ-021 A new group MAY issue in the cycle after completion, giving full throughput of FETCH_W per cycle when mem_rdy_i is all 1.
REQ-022 out_val_o[k] SHALL be 1 iff k < count_o; out_instr_o[k] and out_pc_o[k] SHALL come from entry rd_ptr+k mod DEPTH.
REQ-023 On each edge, count SHALL update as count + enq - min(deq_cnt_i, count_o), and rd_ptr SHALL advance by the same clamped dequeue.
REQ-024 redirect_i SHALL flush the queue (count 0), discard any pending group and its latches, drop a same-cycle enqueue, and load pc <= redirect_pc_i.
REQ-025 When redirect_i is high, mem_val_o SHALL be 0 in that cycle.
REQ-026 halt_i SHALL flush as REQ-024, leave pc unchanged, and enter HALTED.
REQ-027 In HALTED, mem_val_o SHALL be 0.
REQ-028 HALTED SHALL be left to RUN when exec_i=0 is sampled or on pc_wen_i.
REQ-029 pc_wen_i SHALL flush as REQ-024, load pc <= pc_i, and enter RUN.
REQ-030 idle_o SHALL be (count_o=0 && no pending group) || halted_o.

Reset
REQ-031 When rst_i is sampled high, SHALL set pc=RESET_PC, count=0, pointers 0, latches clear, state RUN and halted_o=0.
REQ-032 While rst_i is high, mem_val_o SHALL be all 0 in that cycle, including reset mid-group; the partial group is discarded.
REQ-033 Out of reset, all out_val_o SHALL be 0 and idle_o SHALL be 1.

Verification
REQ-034 Run, FETCH_W=2, rdy always 1, deq 0 -> mem_addr 10/11, 12/13, 14/15, 16/17; count 2,4,6,8; then mem_val_o=0 while full.
REQ-035 Port1 rdy delayed 3 cycles -> port0 val drops after cycle 1; one enqueue of {pc10, pc11} on port1 handshake; pc_o goes 10->12 only then.
REQ-036 Queue at 6 entries, deq_cnt=2 with an enqueue in the same cycle -> count stays 6; out_pc_o shows the next two in order across pointer wrap.
REQ-037 Redirect to 0x40 with a group pending and 4 entries queued -> next cycle count 0, pc_o 0x40, stale rdata never enqueued.
REQ-038 Step mode, pc 0xFF -> single fetch of 0xFF, next fetch 0x00 only after count returns to 0; port1 mem_val_o stays 0.
REQ-039 halt_i then exec_i held 1 -> no fetch, halted_o=1; exec_i=0 for one cycle then 1 -> fetch resumes at the unchanged pc.
